// File: rtl/adbg_ahb3_pkg.sv
// Shared types for the AHB3 debug BIU arbiter: state encoding and pointer helper.
package adbg_ahb3_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

    // Next round-robin position after idx, wrapping modulo n.
    function automatic int rr_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/adbg_rr_pick.sv
// Combinational picker: first set bit of eligible at or after ptr, wrapping modulo NREQ.
module adbg_rr_pick #(
    parameter int NREQ = 2,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [IW-1:0]   ptr,
    output logic            valid,
    output logic [IW-1:0]   idx
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [IW-1:0]     off;
    logic [IW:0]       sum;

    assign dbl = {eligible, eligible} >> ptr;
    assign rot = dbl[NREQ-1:0];

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        valid = 1'b0;
        off   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                valid = 1'b1;
                off   = IW'(k);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        idx = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ)) : IW'(sum);
    end

endmodule

// File: rtl/adbg_ahb3_biu_arb.sv
// Round-robin arbiter sharing one adbg_ahb3_biu port between NREQ debug requesters.
// Optional priority lock is enabled with `define ADBG_BIU_ARB_LOCK_EN.
module adbg_ahb3_biu_arb
    import adbg_ahb3_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int IW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                       biu_clk,
    input  logic                       biu_rst,
    input  logic [NREQ-1:0]            req_strb,
    input  logic [NREQ-1:0]            req_rw,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NREQ*DATA_WIDTH-1:0] req_di,
    input  logic [NREQ*4-1:0]          req_word_size,
`ifdef ADBG_BIU_ARB_LOCK_EN
    input  logic [NREQ-1:0]            req_lock,
`endif
    output logic [NREQ-1:0]            req_ack,
    output logic [DATA_WIDTH-1:0]      req_do,
    output logic                       req_err,
    output logic [IW-1:0]              grant_id,
    output logic                       biu_strb,
    output logic                       biu_rw,
    output logic [ADDR_WIDTH-1:0]      biu_addr,
    output logic [DATA_WIDTH-1:0]      biu_di,
    output logic [3:0]                 biu_word_size,
    input  logic [DATA_WIDTH-1:0]      biu_do,
    input  logic                       biu_rdy,
    input  logic                       biu_err
);

    arb_state_t      state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;
    logic [NREQ-1:0] eligible;
    logic            hold_off;

    // The requester acked this cycle still holds its strobe; mask it.
    assign eligible = req_strb & ~req_ack;

    adbg_rr_pick #(.NREQ(NREQ)) u_pick (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .valid    (pick_valid),
        .idx      (pick_idx)
    );

`ifdef ADBG_BIU_ARB_LOCK_EN
    logic lock_held;
    // A locked requester in its ack cycle is masked; wait for it rather than grant another.
    assign hold_off = lock_held && req_strb[rr_ptr] && req_ack[rr_ptr];
`else
    assign hold_off = 1'b0;
`endif

    always_comb begin
        biu_rw        = 1'b0;
        biu_addr      = '0;
        biu_di        = '0;
        biu_word_size = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == IW'(i)) begin
                biu_rw        = req_rw[i];
                biu_addr      = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                biu_di        = req_di[i*DATA_WIDTH +: DATA_WIDTH];
                biu_word_size = req_word_size[i*4 +: 4];
            end
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge biu_clk) begin
        if (biu_rst) begin
            state    <= ARB_IDLE;
            biu_strb <= 1'b0;
            req_ack  <= '0;
            req_do   <= '0;
            req_err  <= 1'b0;
            grant_id <= '0;
            rr_ptr   <= '0;
`ifdef ADBG_BIU_ARB_LOCK_EN
            lock_held <= 1'b0;
`endif
        end else begin
            req_ack <= '0;
            case (state)
                ARB_IDLE: begin
                    if (pick_valid && biu_rdy && !hold_off) begin
                        grant_id <= pick_idx;
                        biu_strb <= 1'b1;
                        state    <= ARB_ISSUE;
                    end
`ifdef ADBG_BIU_ARB_LOCK_EN
                    if (lock_held && !req_strb[rr_ptr]) begin
                        rr_ptr    <= IW'(rr_inc(int'(rr_ptr), NREQ));
                        lock_held <= 1'b0;
                    end
`endif
                end
                ARB_ISSUE: begin
                    biu_strb <= 1'b0;
                    state    <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    if (biu_rdy) begin
                        req_do            <= biu_do;
                        req_err           <= biu_err;
                        req_ack[grant_id] <= 1'b1;
                        state             <= ARB_IDLE;
`ifdef ADBG_BIU_ARB_LOCK_EN
                        if (req_lock[grant_id]) begin
                            rr_ptr    <= grant_id;
                            lock_held <= 1'b1;
                        end else begin
                            rr_ptr    <= IW'(rr_inc(int'(grant_id), NREQ));
                            lock_held <= 1'b0;
                        end
`else
                        rr_ptr <= IW'(rr_inc(int'(grant_id), NREQ));
`endif
                    end
                end
                default: begin
                    biu_strb <= 1'b0;
                    state    <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adbg_ahb3_biu_arb.sv
// Directed bench for adbg_ahb3_biu_arb (NREQ=2) with a behavioural BIU responder.
module tb_adbg_ahb3_biu_arb;
    import adbg_ahb3_pkg::*;

    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic              biu_clk = 1'b0;
    logic              biu_rst;
    logic [NREQ-1:0]   req_strb, req_rw;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_di;
    logic [NREQ*4-1:0] req_word_size;
`ifdef ADBG_BIU_ARB_LOCK_EN
    logic [NREQ-1:0]   req_lock;
`endif
    logic [NREQ-1:0]   req_ack;
    logic [DW-1:0]     req_do;
    logic              req_err;
    logic [0:0]        grant_id;
    logic              biu_strb, biu_rw;
    logic [AW-1:0]     biu_addr;
    logic [DW-1:0]     biu_di;
    logic [3:0]        biu_word_size;
    logic [DW-1:0]     biu_do;
    logic              biu_rdy, biu_err;

    adbg_ahb3_biu_arb #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .biu_clk       (biu_clk),
        .biu_rst       (biu_rst),
        .req_strb      (req_strb),
        .req_rw        (req_rw),
        .req_addr      (req_addr),
        .req_di        (req_di),
        .req_word_size (req_word_size),
`ifdef ADBG_BIU_ARB_LOCK_EN
        .req_lock      (req_lock),
`endif
        .req_ack       (req_ack),
        .req_do        (req_do),
        .req_err       (req_err),
        .grant_id      (grant_id),
        .biu_strb      (biu_strb),
        .biu_rw        (biu_rw),
        .biu_addr      (biu_addr),
        .biu_di        (biu_di),
        .biu_word_size (biu_word_size),
        .biu_do        (biu_do),
        .biu_rdy       (biu_rdy),
        .biu_err       (biu_err)
    );

    always #5 biu_clk = ~biu_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // BIU model controls and monitor records
    int              lat       = 2;
    logic [DW-1:0]   resp_do   = '0;
    logic            resp_err  = 1'b0;
    logic            hold_busy = 1'b0;
    int              cnt       = 0;
    logic            busy      = 1'b0;
    logic            prev_strb = 1'b0;
    int              strb_n    = 0;
    int              strb_bad  = 0;
    int              strb_dbl  = 0;
    int              strb_cyc  = 0;
    logic            s_rw;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_di;
    logic [3:0]      s_ws;
    int              strb_g_q[$];
    logic [NREQ-1:0] ack_q[$];
    int              ack_cyc   = 0;
    int              rise_cyc  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge biu_clk);
            #1;
        end
    endtask

    task automatic wait_acks(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (ack_q.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, 64'(ack_q.size()), 64'(n));
    endtask

    task automatic clear_log();
        strb_n = 0;
        strb_g_q.delete();
        ack_q.delete();
    endtask

    initial forever begin
        @(posedge biu_clk);
        cyc++;
    end

    // Monitor then BIU responder, both sampled on the falling edge.
    initial begin
        biu_rdy = 1'b1;
        biu_do  = '0;
        biu_err = 1'b0;
        forever begin
            @(negedge biu_clk);
            if (biu_strb) begin
                strb_n++;
                strb_cyc = cyc;
                strb_g_q.push_back(int'(grant_id));
                s_rw = biu_rw; s_addr = biu_addr; s_di = biu_di; s_ws = biu_word_size;
                if (!biu_rdy) strb_bad++;
                if (prev_strb) strb_dbl++;
            end
            prev_strb = biu_strb;
            if (req_ack != '0) begin
                ack_q.push_back(req_ack);
                ack_cyc = cyc;
            end
            if (biu_rst) begin
                biu_rdy = 1'b1;
                busy    = 1'b0;
            end else if (busy) begin
                if (cnt <= 1) begin
                    biu_rdy  = 1'b1;
                    biu_do   = resp_do;
                    biu_err  = resp_err;
                    busy     = 1'b0;
                    rise_cyc = cyc;
                end else begin
                    cnt--;
                end
            end else if (biu_strb) begin
                biu_rdy = 1'b0;
                busy    = 1'b1;
                cnt     = lat;
            end else begin
                biu_rdy = !hold_busy;
            end
        end
    end

    initial begin
        int t0;
        int k;
        biu_rst       = 1'b1;
        req_strb      = '0;
        req_rw        = '0;
        req_addr      = '0;
        req_di        = '0;
        req_word_size = '0;
`ifdef ADBG_BIU_ARB_LOCK_EN
        req_lock      = '0;
`endif
        tick(3);
        check("rst_strb",  64'(biu_strb), 64'd0);
        check("rst_ack",   64'(req_ack),  64'd0);
        check("rst_do",    64'(req_do),   64'd0);
        check("rst_err",   64'(req_err),  64'd0);
        check("rst_grant", 64'(grant_id), 64'd0);
        biu_rst = 1'b0;
        tick(2);

        // Single read by requester 0
        clear_log();
        lat = 5; resp_do = 32'hDEADBEEF; resp_err = 1'b0;
        req_addr[0 +: AW] = 32'h0000_1000; req_rw[0] = 1'b1; req_word_size[3:0] = 4'd4;
        t0 = cyc;
        req_strb = 2'b01;
        wait_acks("rd_ack_cnt", 1, 50);
        req_strb = 2'b00;
        check("rd_strb_lat", 64'(strb_cyc - t0), 64'd1);
        check("rd_addr",     64'(s_addr), 64'h1000);
        check("rd_rw",       64'(s_rw), 64'd1);
        check("rd_ack",      64'(ack_q[0]), 64'b01);
        check("rd_ack_lat",  64'(ack_cyc - rise_cyc), 64'd1);
        check("rd_do",       64'(req_do), 64'hDEADBEEF);
        check("rd_err",      64'(req_err), 64'd0);
        tick(3);
        check("rd_one_ack",  64'(ack_q.size()), 64'd1);
        check("rd_one_strb", 64'(strb_n), 64'd1);
        check("rd_do_hold",  64'(req_do), 64'hDEADBEEF);

        // Write with bus error by requester 1 (pointer now 1)
        clear_log();
        lat = 2; resp_do = 32'h1234_5678; resp_err = 1'b1;
        req_addr[AW +: AW] = 32'h0000_2004; req_rw[1] = 1'b0;
        req_di[DW +: DW] = 32'hA5A5A5A5; req_word_size[7:4] = 4'd4;
        req_strb = 2'b10;
        wait_acks("wr_ack_cnt", 1, 50);
        req_strb = 2'b00;
        check("wr_grant", 64'(strb_g_q[0]), 64'd1);
        check("wr_rw",    64'(s_rw), 64'd0);
        check("wr_addr",  64'(s_addr), 64'h2004);
        check("wr_di",    64'(s_di), 64'hA5A5A5A5);
        check("wr_ws",    64'(s_ws), 64'd4);
        check("wr_ack",   64'(ack_q[0]), 64'b10);
        check("wr_err",   64'(req_err), 64'd1);
        resp_err = 1'b0;
        tick(2);

        // Fairness: both requesters held for six accesses (pointer now 0)
        clear_log();
        req_rw = 2'b11;
        req_strb = 2'b11;
        wait_acks("fair_cnt", 6, 200);
        req_strb = 2'b00;
        for (int i = 0; i < 6; i++)
            check($sformatf("fair_ack%0d", i), 64'(ack_q[i]), (i % 2 == 0) ? 64'b01 : 64'b10);
        tick(3);

        // Busy BIU: no strobe while biu_rdy is low
        clear_log();
        hold_busy = 1'b1;
        tick(1);
        req_strb = 2'b11;
        tick(5);
        check("busy_no_strb", 64'(strb_n), 64'd0);
        hold_busy = 1'b0;
        wait_acks("busy_ack_cnt", 1, 50);
        req_strb = 2'b00;
        check("busy_grant", 64'(strb_g_q[0]), 64'd0);
        check("busy_ack",   64'(ack_q[0]), 64'b01);
        tick(3);
        check("busy_one_strb", 64'(strb_n), 64'd1);

        // Reset while waiting on the BIU
        clear_log();
        lat = 20;
        req_strb = 2'b01;
        k = 0;
        while (strb_n == 0 && k < 20) begin
            tick(1);
            k++;
        end
        check("mid_strb_seen", 64'(strb_n), 64'd1);
        tick(2);
        biu_rst  = 1'b1;
        req_strb = 2'b10;
        tick(1);
        check("mid_state", 64'(dut.state), 64'(ARB_IDLE));
        check("mid_ack",   64'(req_ack),   64'd0);
        check("mid_strb",  64'(biu_strb),  64'd0);
        check("mid_grant", 64'(grant_id),  64'd0);
        check("mid_do",    64'(req_do),    64'd0);
        biu_rst = 1'b0;
        lat = 2;
        wait_acks("mid_ack_cnt", 1, 50);
        req_strb = 2'b00;
        check("mid_post_ack",   64'(ack_q[0]), 64'b10);
        check("mid_post_grant", 64'(strb_g_q[strb_g_q.size()-1]), 64'd1);
        tick(3);

`ifdef ADBG_BIU_ARB_LOCK_EN
        // Lock on requester 0 (pointer now 0)
        clear_log();
        req_lock = 2'b01;
        req_strb = 2'b11;
        wait_acks("lock_cnt2", 2, 100);
        req_lock = 2'b00;
        wait_acks("lock_cnt4", 4, 100);
        req_strb = 2'b00;
        check("lock_ack0", 64'(ack_q[0]), 64'b01);
        check("lock_ack1", 64'(ack_q[1]), 64'b01);
        check("lock_ack2", 64'(ack_q[2]), 64'b01);
        check("lock_ack3", 64'(ack_q[3]), 64'b10);
        tick(3);
`endif

        check("strb_while_busy", 64'(strb_bad), 64'd0);
        check("strb_multi_cyc",  64'(strb_dbl), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
